// File: rtl/scale_writer.sv
// Nearest-neighbour Q8.8 downscaler feeding the scale cache write port.
// Keeps source pixels whose (sx,sy) hit the integer part of the x/y step accumulators.
package structs;
  localparam int SCW_X_W = 9;
  localparam int SCW_Y_W = 8;
  typedef struct packed {
    logic [SCW_Y_W-1:0] waddrY;
    logic [SCW_X_W-1:0] waddrX;
    logic [7:0]         wdata;
    logic               we;
  } struct_scaleCache_Write;
endpackage

module scale_writer #(
  parameter int SRC_W = 320,
  parameter int SRC_H = 240,
  parameter int X_W   = 9,   // must match structs::SCW_X_W
  parameter int Y_W   = 8,   // must match structs::SCW_Y_W
  parameter int FRAC  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [15:0]                    step,
  input  logic                           pix_valid,
  input  logic [7:0]                     pix_data,
  output logic                           pix_ready,
  output structs::struct_scaleCache_Write scw,
  output logic                           busy,
  output logic                           done,
  output logic [X_W-1:0]                 dst_w,
  output logic [Y_W-1:0]                 dst_h
);
  localparam int AXW = X_W + FRAC;
  localparam int AYW = Y_W + FRAC;
  localparam logic [X_W-1:0] SX_LAST = X_W'(SRC_W - 1);
  localparam logic [Y_W-1:0] SY_LAST = Y_W'(SRC_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;

  logic [15:0]    step_q;
  logic [X_W-1:0] sx, dx, dx_n;
  logic [Y_W-1:0] sy, dy, dy_n;
  logic [AXW-1:0] acc_x, acc_x_sat;
  logic [AYW-1:0] acc_y, acc_y_sat;
  logic [AXW:0]   ax_sum;
  logic [AYW:0]   ay_sum;
  logic           row_kept, row_kept_n;
  logic           accept, keep, sx_last, sy_last;

  assign pix_ready = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  assign accept  = pix_valid && (state == RUN);
  assign sx_last = (sx == SX_LAST);
  assign sy_last = (sy == SY_LAST);
  // Saturated accumulators never drop below sx, so an integer-part hit is the keep test.
  assign keep    = accept && (sx == acc_x[AXW-1:FRAC]) && (sy == acc_y[AYW-1:FRAC]);

  assign ax_sum    = {1'b0, acc_x} + (AXW+1)'(step_q);
  assign ay_sum    = {1'b0, acc_y} + (AYW+1)'(step_q);
  assign acc_x_sat = ax_sum[AXW] ? '1 : ax_sum[AXW-1:0];
  assign acc_y_sat = ay_sum[AYW] ? '1 : ay_sum[AYW-1:0];

  // Values including the pixel being accepted now; used at row/frame end.
  assign row_kept_n = row_kept | keep;
  assign dx_n       = keep ? dx + 1'b1 : dx;
  assign dy_n       = row_kept_n ? dy + 1'b1 : dy;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (accept && sx_last && sy_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q   <= '0;
      sx       <= '0;
      sy       <= '0;
      dx       <= '0;
      dy       <= '0;
      acc_x    <= '0;
      acc_y    <= '0;
      row_kept <= 1'b0;
      scw      <= '0;
      dst_w    <= '0;
      dst_h    <= '0;
    end else begin
      scw.we <= keep;
      if (state == IDLE && start) begin
        step_q   <= (step < 16'h0100) ? 16'h0100 : step;
        sx       <= '0;
        sy       <= '0;
        dx       <= '0;
        dy       <= '0;
        acc_x    <= '0;
        acc_y    <= '0;
        row_kept <= 1'b0;
      end
      if (keep) begin
        scw.waddrY <= dy;
        scw.waddrX <= dx;
        scw.wdata  <= pix_data;
      end
      if (accept) begin
        if (sx_last) begin
          sx       <= '0;
          dx       <= '0;
          acc_x    <= '0;
          row_kept <= 1'b0;
          sy       <= sy + 1'b1;
          if (row_kept_n) begin
            acc_y <= acc_y_sat;
            dy    <= dy + 1'b1;
          end
          if (sy == '0) dst_w <= dx_n;
          if (sy_last)  dst_h <= dy_n;
        end else begin
          sx       <= sx + 1'b1;
          row_kept <= row_kept_n;
          if (keep) begin
            dx    <= dx + 1'b1;
            acc_x <= acc_x_sat;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_scale_writer.sv
// Bench for scale_writer: three instances (4x4, 8x4, 6x3) checked against a
// scoreboard of expected writes derived from k*step nearest-neighbour sampling.
module tb_scale_writer;
  logic        clk;
  logic        rst_n;
  logic        start     [3];
  logic [15:0] step      [3];
  logic        pix_valid [3];
  logic [7:0]  pix_data  [3];
  logic        pix_ready [3];
  structs::struct_scaleCache_Write scw [3];
  logic        busy      [3];
  logic        done      [3];
  logic [8:0]  dst_w     [3];
  logic [7:0]  dst_h     [3];

  int SW [3] = '{4, 8, 6};
  int SH [3] = '{4, 4, 3};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    scale_writer #(
      .SRC_W(g == 0 ? 4 : (g == 1 ? 8 : 6)),
      .SRC_H(g == 0 ? 4 : (g == 1 ? 4 : 3)),
      .X_W(9), .Y_W(8), .FRAC(8)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .step(step[g]),
      .pix_valid(pix_valid[g]), .pix_data(pix_data[g]), .pix_ready(pix_ready[g]),
      .scw(scw[g]), .busy(busy[g]), .done(done[g]), .dst_w(dst_w[g]), .dst_h(dst_h[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int y; int x; int data; int due; } exp_t;
  exp_t q[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Coordinate s is sampled iff s == floor(k*stp/256) for some k; idx = k.
  function automatic bit kept_coord(int s, int stp, int lim, output int idx);
    idx = 0;
    for (int k = 0; ((k * stp) >> 8) < lim; k++)
      if (((k * stp) >> 8) == s) begin idx = k; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0; step[d] = '0; pix_valid[d] = 1'b0; pix_data[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if ({busy[d], done[d], pix_ready[d], scw[d], dst_w[d], dst_h[d]} !== '0)
        $display("FAIL reset_state dut%0d: busy=%b done=%b ready=%b scw=%h dst_w=%0d dst_h=%0d, required all 0",
                 d, busy[d], done[d], pix_ready[d], scw[d], dst_w[d], dst_h[d]);
      else n_pass++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_frame(int d, int stp, bit gaps, bit mid_start, int exp_w, int exp_h, string nm);
    int eff, p, npix, done_cnt, t, ix, iy;
    exp_t e;
    eff = (stp < 256) ? 256 : stp;
    npix = SW[d] * SH[d];
    q.delete();
    step[d] = 16'(stp); start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0; step[d] = 16'h0300;
    n_chk++;
    if (pix_ready[d] !== 1'b1 || busy[d] !== 1'b1)
      $display("FAIL %s_ready_after_start: ready=%b busy=%b, required 1/1", nm, pix_ready[d], busy[d]);
    else n_pass++;
    p = 0; done_cnt = 0; t = 0;
    while (t < 2000) begin
      if (scw[d].we === 1'b1) begin
        n_chk++;
        if (q.size() == 0)
          $display("FAIL %s_write: unexpected write y=%0d x=%0d data=%0d, required none", nm,
                   scw[d].waddrY, scw[d].waddrX, scw[d].wdata);
        else begin
          e = q.pop_front();
          if (scw[d].waddrY !== 8'(e.y) || scw[d].waddrX !== 9'(e.x) ||
              scw[d].wdata !== 8'(e.data) || cyc != e.due)
            $display("FAIL %s_write: got y=%0d x=%0d data=%0d cyc=%0d, required y=%0d x=%0d data=%0d cyc=%0d",
                     nm, scw[d].waddrY, scw[d].waddrX, scw[d].wdata, cyc, e.y, e.x, e.data, e.due);
          else n_pass++;
        end
      end
      if (done[d] === 1'b1) done_cnt++;
      if (done_cnt > 0) break;
      start[d] = (mid_start && p >= 5 && p < 8);
      if (p < npix) begin
        pix_valid[d] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_data[d]  = 8'(p);
        if (pix_valid[d] && pix_ready[d]) begin
          if (kept_coord(p % SW[d], eff, SW[d], ix) && kept_coord(p / SW[d], eff, SH[d], iy))
            q.push_back('{y: iy, x: ix, data: p & 255, due: cyc + 1});
          p++;
        end
      end else pix_valid[d] = 1'b0;
      @(negedge clk);
      t++;
    end
    pix_valid[d] = 1'b0; start[d] = 1'b0;
    n_chk++;
    if (done_cnt != 1) $display("FAIL %s_done: done seen %0d times in %0d cycles, required 1", nm, done_cnt, t);
    else n_pass++;
    n_chk++;
    if (q.size() != 0) $display("FAIL %s_missing_writes: %0d left, required 0", nm, q.size());
    else n_pass++;
    n_chk++;
    if (dst_w[d] !== 9'(exp_w) || dst_h[d] !== 8'(exp_h))
      $display("FAIL %s_dims: dst_w=%0d dst_h=%0d, required %0d %0d", nm, dst_w[d], dst_h[d], exp_w, exp_h);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (done[d] !== 1'b0 || busy[d] !== 1'b0 || pix_ready[d] !== 1'b0 || scw[d].we !== 1'b0)
      $display("FAIL %s_idle_after: done=%b busy=%b ready=%b we=%b, required 0", nm,
               done[d], busy[d], pix_ready[d], scw[d].we);
    else n_pass++;
  endtask

  task automatic test_identity();    run_frame(0, 16'h0100, 0, 0, 4, 4, "identity");   endtask
  task automatic test_half();        run_frame(1, 16'h0200, 0, 0, 4, 2, "half");       endtask
  task automatic test_fractional();  run_frame(2, 16'h0180, 0, 0, 4, 2, "fractional"); endtask
  task automatic test_backpressure();
    run_frame(0, 16'h0100, 1, 0, 4, 4, "gaps");
    run_frame(2, 16'h0180, 1, 0, 4, 2, "gaps_frac");
  endtask
  task automatic test_clamp_ignore(); run_frame(0, 16'h0080, 0, 1, 4, 4, "clamp_midstart"); endtask

  task automatic test_reset_mid_frame();
    int acc;
    acc = 0;
    step[0] = 16'h0100; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    while (acc < 5 && cyc < 50000) begin
      pix_valid[0] = 1'b1; pix_data[0] = 8'(acc);
      if (pix_ready[0]) acc++;
      @(negedge clk);
    end
    pix_valid[0] = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy[0] !== 1'b0 || scw[0].we !== 1'b0 || dst_w[0] !== 9'd0 || done[0] !== 1'b0 || acc != 5)
      $display("FAIL reset_mid_frame: busy=%b we=%b dst_w=%0d done=%b accepts=%0d, required 0 0 0 0 5",
               busy[0], scw[0].we, dst_w[0], done[0], acc);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 16'h0100, 0, 0, 4, 4, "after_reset");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_half();
    test_fractional();
    test_backpressure();
    test_clamp_ignore();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
